serial_shifter: RTL and testbench
=================================

SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 The block SHALL have parameter OPERAND_WIDTH, default 16, setting the operand and result width.
REQ-002 The block SHALL have parameter SHAMT_WIDTH, default 4, setting the shift-amount width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: request present on In/ShAmt/Oper.
REQ-007 Port in_ready, output, 1 bit: block can accept a request.
REQ-008 Port In, input, OPERAND_WIDTH bits: operand.
REQ-009 Port ShAmt, input, SHAMT_WIDTH bits: shift/rotate amount, 0..2^SHAMT_WIDTH-1.
REQ-010 Port Oper, input, 2 bits: 00 rotate right, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical.
REQ-011 Port out_valid, output, 1 bit: Out holds a completed result.
REQ-012 Port out_ready, input, 1 bit: consumer takes the result.
REQ-013 Port Out, output, OPERAND_WIDTH bits: result.
REQ-014 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be high only in IDLE; a request is accepted on an edge where in_valid and in_ready are both high.
REQ-017 On acceptance the block SHALL register In into a data register, Oper into an op register, and ShAmt into a down-counter.
REQ-018 On acceptance with ShAmt=0, the next state SHALL be DONE with the data register holding In unchanged.
REQ-019 On acceptance with ShAmt!=0, the next state SHALL be SHIFT.
REQ-020 In SHIFT, each cycle SHALL apply one 1-bit step per the registered op and decrement the counter.
REQ-021 Rotate right: bit 0 moves to the MSB.
REQ-022 SLL: shift left, fill 0 at bit 0.
REQ-023 SRA: shift right, replicate the MSB.
REQ-024 SRL: shift right, fill 0 at the MSB.
REQ-025 When the counter equals 1 during SHIFT, the next state SHALL be DONE after that final step.
REQ-026 out_valid SHALL be asserted exactly ShAmt+1 rising edges after the accepting edge.
REQ-027 In DONE, out_valid SHALL be high and Out SHALL equal the data register, both stable until handshake.
REQ-028 When out_ready is high in DONE, the next state SHALL be IDLE; otherwise the block SHALL remain in DONE.
REQ-029 A new request SHALL NOT be accepted in the DONE-to-IDLE cycle; acceptance requires IDLE, giving 1 idle cycle minimum between results.
REQ-030 In_valid and input changes during SHIFT or DONE SHALL have no effect on the result in progress.
REQ-031 Out SHALL be the data register in all states; it is meaningful only while out_valid is high.
REQ-032 The result SHALL equal the combinational definition of the same op by ShAmt bits for every ShAmt, including 2^SHAMT_WIDTH-1.

Reset
REQ-033 When rst_n is low at a rising edge, the state SHALL go to IDLE, and the data register, op register and counter SHALL go to 0.
REQ-034 After reset, out_valid=0, busy=0, in_ready=1 and Out=0.
REQ-035 Reset asserted during SHIFT or DONE SHALL abort the operation with no out_valid pulse.

Verification
REQ-036 ROR: In=0x0001, ShAmt=1 -> Out=0x8000, with out_valid high 2 edges after accept.
REQ-037 SLL: In=0x00FF, ShAmt=4 -> Out=0x0FF0 after 5 edges; SRL: In=0x8000, ShAmt=15 -> Out=0x0001 after 16 edges.
REQ-038 SRA: In=0x8000, ShAmt=15 -> Out=0xFFFF; SRA: In=0x4000, ShAmt=14 -> Out=0x0001.
REQ-039 ShAmt=0, In=0x1234, any Oper -> Out=0x1234, with out_valid 1 edge after accept.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle In/in_valid -> Out, out_valid and in_ready=0 stay stable; the result drains on out_ready=1.
REQ-041 Drive rst_n=0 mid-SHIFT (ShAmt=8, after 3 steps) -> next edge gives IDLE, Out=0, out_valid=0, in_ready=1, and no stale result afterwards.

Source files
------------

// File: rtl/serial_shifter.sv
// Multi-cycle shifter/rotator: one 1-bit step per clock, ShAmt steps per request.
// The result is held with out_valid/out_ready until the consumer takes it.
module serial_shifter #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] In,
  input  logic [SHAMT_WIDTH-1:0]   ShAmt,
  input  logic [1:0]               Oper,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] Out,
  output logic                     busy
);

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t                   state_q, state_d;
  logic [OPERAND_WIDTH-1:0] data_q,  data_d;
  logic [1:0]               op_q,    op_d;
  logic [SHAMT_WIDTH-1:0]   cnt_q,   cnt_d;

  function automatic logic [OPERAND_WIDTH-1:0] step1(
    input logic [OPERAND_WIDTH-1:0] d,
    input logic [1:0]               op
  );
    logic [OPERAND_WIDTH-1:0] r;
    case (op)
      OP_ROR:  r = {d[0], d[OPERAND_WIDTH-1:1]};
      OP_SLL:  r = {d[OPERAND_WIDTH-2:0], 1'b0};
      OP_SRA:  r = {d[OPERAND_WIDTH-1], d[OPERAND_WIDTH-1:1]};
      OP_SRL:  r = {1'b0, d[OPERAND_WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = In;
          op_d    = Oper;
          cnt_d   = ShAmt;
          // A zero amount skips SHIFT entirely and presents the operand as-is.
          state_d = (ShAmt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step1(data_q, op_q);
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Out       = data_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Randomized bench for serial_shifter against a whole-word arithmetic reference model.
module tb_serial_shifter;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  In = '0;
  logic [SW-1:0] ShAmt = '0;
  logic [1:0]    Oper = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [W-1:0]  Out;

  int n_checks = 0;
  int n_errors = 0;

  serial_shifter #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (In),
    .ShAmt     (ShAmt),
    .Oper      (Oper),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [W-1:0] x, input int s,
                                             input logic [1:0] op);
    logic signed [W-1:0] sx;
    sx = x;
    case (op)
      2'b00:   return (s == 0) ? x : ((x >> s) | (x << (W - s)));
      2'b01:   return x << s;
      2'b10:   return sx >>> s;
      default: return x >> s;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] x, input int s, input logic [1:0] op,
                        input int hold);
    logic [W-1:0] exp;
    logic [W-1:0] held;
    int k;
    exp = ref_model(x, s, op);
    check("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    In        = x;
    ShAmt     = s[SW-1:0];
    Oper      = op;
    out_ready = 1'b0;
    tick();
    k = 1;
    while (!out_valid && k < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      In       = W'($urandom);
      ShAmt    = SW'($urandom);
      Oper     = 2'($urandom);
      tick();
      k++;
    end
    check("latency", 32'(k), 32'(s + 1));
    check("result", 32'(Out), 32'(exp));
    check("busy_done", 32'(busy), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
    held = Out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      In       = W'($urandom);
      ShAmt    = SW'($urandom);
      tick();
      check("hold_out", 32'(Out), 32'(held));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    In        = W'($urandom);
    ShAmt     = SW'($urandom_range(1, 15));
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("no_accept_in_drain", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out"}, 32'(Out), 32'd0);
  endtask

  initial begin
    logic saw_valid;
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    run_op(16'h0001, 1, 2'b00, 0);
    run_op(16'h00FF, 4, 2'b01, 0);
    run_op(16'h8000, 15, 2'b11, 0);
    run_op(16'h8000, 15, 2'b10, 0);
    run_op(16'h4000, 14, 2'b10, 0);
    for (int o = 0; o < 4; o++) run_op(16'h1234, 0, 2'(o), 1);
    run_op(16'hBEEF, 15, 2'b00, 0);
    run_op(16'hC3A5, 7, 2'b10, 5);

    // Reset in the middle of a shift must abort with no result.
    in_valid = 1'b1;
    In       = 16'hA5A5;
    ShAmt    = 4'd8;
    Oper     = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check_reset_state("mid_reset");
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("no_stale_result", 32'(saw_valid), 32'd0);

    // Reset while holding a result in DONE.
    in_valid = 1'b1;
    In       = 16'h5A5A;
    ShAmt    = 4'd0;
    tick();
    in_valid = 1'b0;
    check("done_before_reset", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check_reset_state("done_reset");
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 60; t++) begin
      run_op(W'($urandom), int'($urandom_range(0, 15)), 2'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
